// File: rtl/collision_pkg.sv
// Shared definitions for the pong collision engine: FSM state codes, hit-zone
// codes, default geometry and an absolute-difference helper.
// No ports; imported by collision_overlap and collision_engine.
package collision_pkg;

   // FSM state codes
   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_CALC   = 2'd1;
   localparam logic [1:0] S_REPORT = 2'd2;

   // Vertical contact zone on a paddle, used for bounce-angle selection
   typedef enum logic [1:0] {
      ZONE_NONE   = 2'b00,
      ZONE_TOP    = 2'b01,
      ZONE_CENTRE = 2'b10,
      ZONE_BOTTOM = 2'b11
   } zone_e;

   // Default geometry
   localparam int DEF_BIT_WIDTH       = 10;
   localparam int DEF_NUM_PADDLES     = 2;
   localparam int DEF_BALL_RADIUS     = 5;
   localparam int DEF_PADDLE_HALF_W   = 2;
   localparam int DEF_PADDLE_HALF_H   = 20;
   localparam int DEF_FLOOR_Y         = 479;
   localparam int DEF_CEIL_Y          = 0;
   localparam int DEF_COOLDOWN_FRAMES = 4;
   localparam int DEF_COUNT_WIDTH     = 8;

   // Width of abs_diff operands; callers zero-extend coordinates into it
   localparam int ABS_W = 16;

   // Unsigned |a - b|, never wraps
   function automatic logic [ABS_W-1:0] abs_diff(input logic [ABS_W-1:0] a,
                                                  input logic [ABS_W-1:0] b);
      return (a >= b) ? (a - b) : (b - a);
   endfunction

endpackage

// File: rtl/collision_overlap.sv
// Combinational box-overlap test of the ball against one paddle.
// Ports: i_ball_x/i_ball_y ball centre, i_pad_x/i_pad_y paddle centre,
//        o_overlap inclusive box overlap, o_zone contact zone (COLLISION_ZONE_EN only).
// Zero latency; no flow control.
module collision_overlap
   import collision_pkg::*;
#(
   parameter int BIT_WIDTH     = DEF_BIT_WIDTH,
   parameter int BALL_RADIUS   = DEF_BALL_RADIUS,
   parameter int PADDLE_HALF_W = DEF_PADDLE_HALF_W,
   parameter int PADDLE_HALF_H = DEF_PADDLE_HALF_H
) (
   input  logic [BIT_WIDTH-1:0] i_ball_x,
   input  logic [BIT_WIDTH-1:0] i_ball_y,
   input  logic [BIT_WIDTH-1:0] i_pad_x,
   input  logic [BIT_WIDTH-1:0] i_pad_y,
   output logic                 o_overlap
`ifdef COLLISION_ZONE_EN
   ,
   output logic [1:0]           o_zone
`endif
);

   // One extra bit so radius additions never wrap
   localparam int W = BIT_WIDTH + 1;
   localparam logic [W-1:0] LIM_X = W'(BALL_RADIUS + PADDLE_HALF_W);
   localparam logic [W-1:0] LIM_Y = W'(BALL_RADIUS + PADDLE_HALF_H);

   logic [W-1:0] w_dx;
   logic [W-1:0] w_dy;

   assign w_dx      = W'(abs_diff(ABS_W'(i_ball_x), ABS_W'(i_pad_x)));
   assign w_dy      = W'(abs_diff(ABS_W'(i_ball_y), ABS_W'(i_pad_y)));
   assign o_overlap = (w_dx <= LIM_X) && (w_dy <= LIM_Y);

`ifdef COLLISION_ZONE_EN
   // Centre band is ball_y - pad_y within +/- HALF_H/3, boundaries included
   localparam logic [W-1:0] ZONE_T = W'(PADDLE_HALF_H / 3);

   logic [W-1:0] w_by;
   logic [W-1:0] w_py;

   assign w_by = {1'b0, i_ball_y};
   assign w_py = {1'b0, i_pad_y};

   always_comb begin
      o_zone = ZONE_CENTRE;
      if ((w_by + ZONE_T) < w_py) begin
         o_zone = ZONE_TOP;
      end else if (w_by > (w_py + ZONE_T)) begin
         o_zone = ZONE_BOTTOM;
      end
   end
`endif

endmodule

// File: rtl/collision_engine.sv
// Frame-synchronous ball/paddle/floor/ceiling collision engine with edge-detected
// hit pulses, paddle-hit cooldown and a saturating paddle-hit counter.
// Latency: frame_tick at edge N -> pulses high in S_REPORT (seen by a consumer at edge N+2).
// Backpressure: none; frame_tick while busy is dropped, not queued.
// Ports: i_clk, i_rst_n (sync, active low), i_frame_tick, i_paddle_x/i_paddle_y (packed
//        per paddle), i_ball_x/i_ball_y, o_paddle_hit (one-hot pulse), o_touching_paddle,
//        o_floor_hit, o_ceil_hit, o_hit_count, o_busy, o_hit_zone (COLLISION_ZONE_EN only).
module collision_engine
   import collision_pkg::*;
#(
   parameter int BIT_WIDTH       = DEF_BIT_WIDTH,
   parameter int NUM_PADDLES     = DEF_NUM_PADDLES,
   parameter int BALL_RADIUS     = DEF_BALL_RADIUS,
   parameter int PADDLE_HALF_W   = DEF_PADDLE_HALF_W,
   parameter int PADDLE_HALF_H   = DEF_PADDLE_HALF_H,
   parameter int FLOOR_Y         = DEF_FLOOR_Y,
   parameter int CEIL_Y          = DEF_CEIL_Y,
   parameter int COOLDOWN_FRAMES = DEF_COOLDOWN_FRAMES,
   parameter int COUNT_WIDTH     = DEF_COUNT_WIDTH
) (
   input  logic                             i_clk,
   input  logic                             i_rst_n,
   input  logic                             i_frame_tick,
   input  logic [NUM_PADDLES*BIT_WIDTH-1:0] i_paddle_x,
   input  logic [NUM_PADDLES*BIT_WIDTH-1:0] i_paddle_y,
   input  logic [BIT_WIDTH-1:0]             i_ball_x,
   input  logic [BIT_WIDTH-1:0]             i_ball_y,
   output logic [NUM_PADDLES-1:0]           o_paddle_hit,
   output logic [NUM_PADDLES-1:0]           o_touching_paddle,
   output logic                             o_floor_hit,
   output logic                             o_ceil_hit,
   output logic [COUNT_WIDTH-1:0]           o_hit_count,
   output logic                             o_busy
`ifdef COLLISION_ZONE_EN
   ,
   output logic [1:0]                       o_hit_zone
`endif
);

   localparam int W    = BIT_WIDTH + 1;
   localparam int CD_W = (COOLDOWN_FRAMES < 1) ? 1 : $clog2(COOLDOWN_FRAMES + 1);

   logic [1:0]                       r_state;
   logic [BIT_WIDTH-1:0]             r_ball_x;
   logic [BIT_WIDTH-1:0]             r_ball_y;
   logic [NUM_PADDLES*BIT_WIDTH-1:0] r_pad_x;
   logic [NUM_PADDLES*BIT_WIDTH-1:0] r_pad_y;
   // r_touch doubles as the previous-overlap flag for edge detection
   logic [NUM_PADDLES-1:0]           r_touch;
   logic [NUM_PADDLES-1:0]           r_paddle_hit;
   logic                             r_floor_lvl;
   logic                             r_ceil_lvl;
   logic                             r_floor_hit;
   logic                             r_ceil_hit;
   logic [CD_W-1:0]                  r_cooldown;
   logic [COUNT_WIDTH-1:0]           r_hit_count;

   logic [NUM_PADDLES-1:0]           w_overlap;
   logic [NUM_PADDLES-1:0]           w_cand;
   logic [NUM_PADDLES-1:0]           w_pick;
   logic                             w_floor;
   logic                             w_ceil;

`ifdef COLLISION_ZONE_EN
   logic [1:0] w_zone [NUM_PADDLES];
   logic [1:0] w_pick_zone;
   logic [1:0] r_zone;
`endif

   for (genvar gi = 0; gi < NUM_PADDLES; gi++) begin : g_pad
      collision_overlap #(
         .BIT_WIDTH     (BIT_WIDTH),
         .BALL_RADIUS   (BALL_RADIUS),
         .PADDLE_HALF_W (PADDLE_HALF_W),
         .PADDLE_HALF_H (PADDLE_HALF_H)
      ) u_overlap (
         .i_ball_x  (r_ball_x),
         .i_ball_y  (r_ball_y),
         .i_pad_x   (r_pad_x[gi*BIT_WIDTH +: BIT_WIDTH]),
         .i_pad_y   (r_pad_y[gi*BIT_WIDTH +: BIT_WIDTH]),
         .o_overlap (w_overlap[gi])
`ifdef COLLISION_ZONE_EN
         ,
         .o_zone    (w_zone[gi])
`endif
      );
   end

   // New contacts only, and only once the cooldown has expired
   assign w_cand = w_overlap & ~r_touch & {NUM_PADDLES{r_cooldown == '0}};
   // Isolate the lowest set bit so simultaneous contacts resolve to one paddle
   assign w_pick = w_cand & (~w_cand + NUM_PADDLES'(1));

   assign w_floor = ({1'b0, r_ball_y} + W'(BALL_RADIUS)) >= W'(FLOOR_Y);
   // Radius is added to the ceiling rather than subtracted from the ball: no underflow
   assign w_ceil  = {1'b0, r_ball_y} <= W'(CEIL_Y + BALL_RADIUS);

`ifdef COLLISION_ZONE_EN
   always_comb begin
      w_pick_zone = ZONE_NONE;
      for (int i = 0; i < NUM_PADDLES; i++) begin
         if (w_pick[i]) begin
            w_pick_zone = w_zone[i];
         end
      end
   end
`endif

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state      <= S_IDLE;
         r_ball_x     <= '0;
         r_ball_y     <= '0;
         r_pad_x      <= '0;
         r_pad_y      <= '0;
         r_touch      <= '0;
         r_paddle_hit <= '0;
         r_floor_lvl  <= 1'b0;
         r_ceil_lvl   <= 1'b0;
         r_floor_hit  <= 1'b0;
         r_ceil_hit   <= 1'b0;
         r_cooldown   <= '0;
         r_hit_count  <= '0;
`ifdef COLLISION_ZONE_EN
         r_zone       <= ZONE_NONE;
`endif
      end else begin
         // Pulses are single-cycle: cleared unless set by S_CALC below
         r_paddle_hit <= '0;
         r_floor_hit  <= 1'b0;
         r_ceil_hit   <= 1'b0;
`ifdef COLLISION_ZONE_EN
         r_zone       <= ZONE_NONE;
`endif
         case (r_state)
            S_IDLE: begin
               if (i_frame_tick) begin
                  r_ball_x <= i_ball_x;
                  r_ball_y <= i_ball_y;
                  r_pad_x  <= i_paddle_x;
                  r_pad_y  <= i_paddle_y;
                  // Cooldown counts accepted frames, so it ages before this frame is judged
                  if (r_cooldown != '0) begin
                     r_cooldown <= r_cooldown - CD_W'(1);
                  end
                  r_state <= S_CALC;
               end
            end
            S_CALC: begin
               r_touch      <= w_overlap;
               r_floor_lvl  <= w_floor;
               r_ceil_lvl   <= w_ceil;
               r_paddle_hit <= w_pick;
               r_floor_hit  <= w_floor & ~r_floor_lvl;
               r_ceil_hit   <= w_ceil & ~r_ceil_lvl;
`ifdef COLLISION_ZONE_EN
               r_zone       <= w_pick_zone;
`endif
               if (|w_pick) begin
                  r_cooldown <= CD_W'(COOLDOWN_FRAMES);
                  if (r_hit_count != '1) begin
                     r_hit_count <= r_hit_count + COUNT_WIDTH'(1);
                  end
               end
               r_state <= S_REPORT;
            end
            S_REPORT: begin
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign o_paddle_hit      = r_paddle_hit;
   assign o_touching_paddle = r_touch;
   assign o_floor_hit       = r_floor_hit;
   assign o_ceil_hit        = r_ceil_hit;
   assign o_hit_count       = r_hit_count;
   assign o_busy            = (r_state != S_IDLE);
`ifdef COLLISION_ZONE_EN
   assign o_hit_zone        = r_zone;
`endif

endmodule
